// File: rtl/rdp_systolic_fork_if.sv
// Handshake bundle for the systolic fork: one source channel in, five consumer
// channels out, sharing a single head payload.
interface rdp_systolic_fork_if #(
  parameter int unsigned DW = 32
);
  logic          t_src_req;
  logic          t_src_ack;
  logic [DW-1:0] t_src_data;
  logic          i_k8_req;
  logic          i_k8_ack;
  logic          i_k9_req;
  logic          i_k9_ack;
  logic          i_k10_req;
  logic          i_k10_ack;
  logic          i_k11_req;
  logic          i_k11_ack;
  logic          i_c_req;
  logic          i_c_ack;
  logic [DW-1:0] i_data;

  modport slave (
    input  t_src_req, t_src_data,
    input  i_k8_ack, i_k9_ack, i_k10_ack, i_k11_ack, i_c_ack,
    output t_src_ack,
    output i_k8_req, i_k9_req, i_k10_req, i_k11_req, i_c_req, i_data
  );

  modport master (
    output t_src_req, t_src_data,
    output i_k8_ack, i_k9_ack, i_k10_ack, i_k11_ack, i_c_ack,
    input  t_src_ack,
    input  i_k8_req, i_k9_req, i_k10_req, i_k11_req, i_c_req, i_data
  );
endinterface

// File: rtl/rdp_systolic_fork.sv
// Eager 1-to-5 fork behind a 2-entry elastic buffer; the head token retires
// once every consumer has taken it exactly once.
module rdp_systolic_fork #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rdp_systolic_fork_if.slave    io,
  output logic                  busy,
  output logic [CW-1:0]         tok_cnt
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [4:0]    done_q, done_d;
  logic          src_ack_q, src_ack_d;
  logic [CW-1:0] tok_q, tok_d;

  logic [4:0]    ack_v;
  logic [4:0]    req_v;
  logic [4:0]    xfer;
  logic          busy_w;
  logic          push;
  logic          pop;

  always_comb begin
    ack_v  = {io.i_c_ack, io.i_k11_ack, io.i_k10_ack, io.i_k9_ack, io.i_k8_ack};
    busy_w = (cnt_q != 2'd0);
    req_v  = {5{busy_w}} & ~done_q;
    xfer   = req_v & ack_v;
    push   = io.t_src_req & src_ack_q;
    // A branch counts as served if it finished earlier or transfers this edge.
    pop    = busy_w & (&(done_q | xfer));

    mem_d = mem_q;
    if (push) mem_d[wr_q] = io.t_src_data;
    wr_d      = wr_q ^ push;
    rd_d      = rd_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    done_d    = pop ? '0 : (done_q | xfer);
    tok_d     = tok_q + CW'(pop);
    // Registered from next occupancy so consumer acks never reach the source combinationally.
    src_ack_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q     <= '{default: '0};
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= '0;
      src_ack_q <= 1'b0;
      tok_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      src_ack_q <= src_ack_d;
      tok_q     <= tok_d;
    end
  end

  assign io.t_src_ack = src_ack_q;
  assign io.i_k8_req  = req_v[0];
  assign io.i_k9_req  = req_v[1];
  assign io.i_k10_req = req_v[2];
  assign io.i_k11_req = req_v[3];
  assign io.i_c_req   = req_v[4];
  assign io.i_data    = mem_q[rd_q];
  assign busy         = busy_w;
  assign tok_cnt      = tok_q;

endmodule

// File: tb/tb_rdp_systolic_fork.sv
// Directed bench for rdp_systolic_fork: streaming, staggered acks, backpressure,
// idle acks, mid-token reset and counter wrap on a narrow-counter instance.
module tb_rdp_systolic_fork;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy, wbusy;
  logic [15:0] tok;
  logic [3:0]  wtok;
  logic [4:0]  reqv, ackv, wreqv;

  int checks   = 0;
  int failures = 0;
  int xcnt [5] = '{default: 0};
  logic [31:0] xlast [5];

  always #5 clk = ~clk;

  rdp_systolic_fork_if #(.DW(32)) io ();
  rdp_systolic_fork_if #(.DW(32)) wio ();

  rdp_systolic_fork #(.DW(32), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .io(io), .busy(busy), .tok_cnt(tok)
  );

  rdp_systolic_fork #(.DW(32), .CW(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .io(wio), .busy(wbusy), .tok_cnt(wtok)
  );

  assign reqv  = {io.i_c_req, io.i_k11_req, io.i_k10_req, io.i_k9_req, io.i_k8_req};
  assign ackv  = {io.i_c_ack, io.i_k11_ack, io.i_k10_ack, io.i_k9_ack, io.i_k8_ack};
  assign wreqv = {wio.i_c_req, wio.i_k11_req, wio.i_k10_req, wio.i_k9_req, wio.i_k8_req};

  // Per-branch transfer log, used to confirm single delivery.
  always @(posedge clk) begin
    for (int b = 0; b < 5; b++) begin
      if (reqv[b] && ackv[b]) begin
        xcnt[b]  <= xcnt[b] + 1;
        xlast[b] <= io.i_data;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acks(input logic [4:0] a);
    io.i_k8_ack  = a[0];
    io.i_k9_ack  = a[1];
    io.i_k10_ack = a[2];
    io.i_k11_ack = a[3];
    io.i_c_ack   = a[4];
  endtask

  task automatic set_wacks(input logic [4:0] a);
    wio.i_k8_ack  = a[0];
    wio.i_k9_ack  = a[1];
    wio.i_k10_ack = a[2];
    wio.i_k11_ack = a[3];
    wio.i_c_ack   = a[4];
  endtask

  // Leaves both DUTs just past the first edge after release (src_ack now 1).
  task automatic do_reset();
    reset_n        = 1'b0;
    io.t_src_req   = 1'b0;
    io.t_src_data  = '0;
    wio.t_src_req  = 1'b0;
    wio.t_src_data = '0;
    set_acks(5'b00000);
    set_wacks(5'b00000);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  int base [5];

  initial begin
    // Test 1: reset state, first token, 100-token stream
    reset_n        = 1'b0;
    io.t_src_req   = 1'b1;
    io.t_src_data  = 32'hA5A5_0001;
    wio.t_src_req  = 1'b0;
    wio.t_src_data = '0;
    set_acks(5'b11111);
    set_wacks(5'b00000);
    #1;
    step();
    step();
    check("rst_src_ack", io.t_src_ack, 0);
    check("rst_req",     reqv, 0);
    check("rst_busy",    busy, 0);
    check("rst_data",    io.i_data, 0);
    check("rst_tok",     tok, 0);
    reset_n = 1'b1;
    step();
    check("t1_src_ack_c1", io.t_src_ack, 1);
    check("t1_req_c1",     reqv, 0);
    step();
    check("t1_req_c2",  reqv, 5'b11111);
    check("t1_data_c2", io.i_data, 32'hA5A5_0001);
    check("t1_tok_c2",  tok, 0);
    io.t_src_data = 32'hA5A5_0002;
    for (int i = 1; i < 100; i++) begin
      step();
      check("t1_stream_tok",  tok, i);
      check("t1_stream_data", io.i_data, 32'hA5A5_0001 + i);
      check("t1_stream_req",  reqv, 5'b11111);
      check("t1_stream_ack",  io.t_src_ack, 1);
      io.t_src_data = 32'hA5A5_0001 + i + 1;
    end
    io.t_src_req = 1'b0;
    step();
    check("t1_tok_100", tok, 100);
    check("t1_empty",   busy, 0);
    check("t1_req_off", reqv, 0);

    // Test 2: staggered acks on one token
    do_reset();
    for (int b = 0; b < 5; b++) base[b] = xcnt[b];
    io.t_src_req  = 1'b1;
    io.t_src_data = 32'h0000_1234;
    step();
    io.t_src_req = 1'b0;
    check("t2_req_all",  reqv, 5'b11111);
    check("t2_data",     io.i_data, 32'h1234);
    set_acks(5'b00001); step(); check("t2_req_k8",  reqv, 5'b11110);
    set_acks(5'b00011); step(); check("t2_req_k9",  reqv, 5'b11100);
    set_acks(5'b00111); step(); check("t2_req_k10", reqv, 5'b11000);
    set_acks(5'b01111); step(); check("t2_req_k11", reqv, 5'b10000);
    check("t2_busy_mid", busy, 1);
    check("t2_tok_mid",  tok, 0);
    set_acks(5'b11111); step();
    check("t2_req_done", reqv, 0);
    check("t2_busy_end", busy, 0);
    check("t2_tok_end",  tok, 1);
    step();
    for (int b = 0; b < 5; b++) begin
      check("t2_once", xcnt[b] - base[b], 1);
      check("t2_seen", xlast[b], 32'h1234);
    end

    // Test 3: backpressure from c
    do_reset();
    for (int b = 0; b < 5; b++) base[b] = xcnt[b];
    set_acks(5'b01111);
    io.t_src_req  = 1'b1;
    io.t_src_data = 32'h11;
    step();
    check("t3_ack_after_11", io.t_src_ack, 1);
    check("t3_head_11",      io.i_data, 32'h11);
    io.t_src_data = 32'h22;
    step();
    check("t3_full_ack",  io.t_src_ack, 0);
    check("t3_req_c",     reqv, 5'b10000);
    io.t_src_data = 32'h33;
    step();
    step();
    check("t3_hold_ack",  io.t_src_ack, 0);
    check("t3_hold_head", io.i_data, 32'h11);
    check("t3_hold_tok",  tok, 0);
    set_acks(5'b11111);
    step();
    check("t3_head_22",   io.i_data, 32'h22);
    check("t3_req_22",    reqv, 5'b11111);
    check("t3_ack_open",  io.t_src_ack, 1);
    check("t3_tok_1",     tok, 1);
    step();
    io.t_src_req = 1'b0;
    check("t3_head_33",   io.i_data, 32'h33);
    check("t3_tok_2",     tok, 2);
    step();
    check("t3_tok_3",     tok, 3);
    check("t3_drained",   busy, 0);
    step();
    check("t3_c_count",   xcnt[4] - base[4], 3);
    check("t3_c_last",    xlast[4], 32'h33);

    // Test 4: acks while empty
    set_acks(5'b11111);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_req",  reqv, 0);
      check("t4_busy", busy, 0);
      check("t4_tok",  tok, 3);
    end

    // Test 5: reset mid-token
    do_reset();
    io.t_src_req  = 1'b1;
    io.t_src_data = 32'h77;
    step();
    io.t_src_req = 1'b0;
    set_acks(5'b00011);
    step();
    check("t5_partial", reqv, 5'b11100);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_ack",  io.t_src_ack, 0);
    check("t5_async_req",  reqv, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_data", io.i_data, 0);
    set_acks(5'b00000);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_replay", reqv, 0);
      check("t5_busy",      busy, 0);
      check("t5_tok",       tok, 0);
    end

    // Test 6: CW=4 wrap
    do_reset();
    set_wacks(5'b11111);
    wio.t_src_req  = 1'b1;
    wio.t_src_data = 32'hBEEF;
    step();
    check("t6_req", wreqv, 5'b11111);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 16) wio.t_src_req = 1'b0;
      check("t6_wrap_tok", wtok, k % 16);
    end
    step();
    check("t6_drained", wbusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rdp_systolic_fork.md
Name: rdp_systolic_fork

Overview:
- Eager fork for the systolic req/ack fabric; the dual of the join controller.
- Accepts one source token and broadcasts it to five consumer channels (k8, k9, k10, k11, c). Each consumer handshakes independently.
- Retires the token only after all five consumers have acknowledged it.
- A 2-entry elastic buffer on the source side cuts the combinational ack path, so upstream never sees downstream ack timing.

Parameters:
DW, 32, payload width in bits
CW, 16, width of retired-token counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
t_src_req  in  1  source token valid
t_src_ack  out  1  source token accepted (registered)
t_src_data  in  DW  source payload
i_k8_req  out  1  token offered to consumer k8
i_k8_ack  in  1  k8 accepts
i_k9_req  out  1  token offered to k9
i_k9_ack  in  1  k9 accepts
i_k10_req  out  1  token offered to k10
i_k10_ack  in  1  k10 accepts
i_k11_req  out  1  token offered to k11
i_k11_ack  in  1  k11 accepts
i_c_req  out  1  token offered to c
i_c_ack  in  1  c accepts
i_data  out  DW  head payload, shared by all five consumers
busy  out  1  buffer non-empty
tok_cnt  out  CW  number of tokens retired, modulo 2^CW

Behaviour:
- Handshake: a transfer occurs on any channel in a cycle where req=1 and ack=1 at the rising edge of clk.
  - Producers hold req and data stable until the transfer.
  - Consumers may assert ack before req; ack without req has no effect.
- Reset (reset_n low, asynchronous):
  - Buffer emptied, all done flags cleared, tok_cnt=0.
  - t_src_ack=0, all i_*_req=0, busy=0, i_data=0.
- t_src_ack:
  - Flop; 1 iff buffer occupancy after the current edge will be < 2.
  - First becomes 1 on the first clk edge after reset_n deasserts.
- Push: t_src_req & t_src_ack writes t_src_data at the tail.
- Head offer: for each branch x in {k8,k9,k10,k11,c}, i_x_req = busy & ~done[x].
  - i_data always shows the head entry.
  - All branches are offered in the same cycle the head becomes valid, i.e. the cycle after the push edge into an empty buffer.
  - Latency from source transfer to consumer req: 1 cycle.
- Done flags: on a transfer on branch x, set done[x], which drops i_x_req the next cycle. Each consumer receives each token exactly once.
- Retire: in the cycle where, for every branch, done[x] | (i_x_req & i_x_ack) holds:
  - Pop the head.
  - Clear all done flags.
  - Increment tok_cnt.
  - If all five branches ack in the same cycle the token is offered, it retires in 1 cycle. Full throughput is 1 token/cycle.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - The new head is offered to all branches the following cycle with cleared done flags.
- Full (2 entries): t_src_ack=0; source req is held off with no data loss.
- Empty: all i_*_req=0; acks are ignored; done flags stay clear.
- tok_cnt wraps 2^CW-1 -> 0 without a flag.
- Reset mid-token: partially delivered tokens are discarded. No replay after reset.
- No combinational path from any i_*_ack to t_src_ack. i_*_req depends only on flops.

Test Plan:
1. Reset release, t_src_req=1 with data 0xA5A5_0001, all acks tied 1:
   - t_src_ack=1 at cycle 1.
   - All five i_*_req=1 with i_data=0xA5A5_0001 at cycle 2.
   - tok_cnt=1 after cycle 2.
   - Sustained stream of 100 tokens gives tok_cnt=100 and 1 token/cycle.
2. Staggered acks on a single token 0x1234:
   - k8 acks cycle 2, k9 cycle 3, k10 cycle 4, k11 cycle 5, c cycle 6.
   - Each req drops the cycle after its ack.
   - Pop after cycle 6; each consumer sees 0x1234 exactly once.
3. Backpressure: c ack held 0, source pushes 0x11, 0x22, 0x33.
   - 0x11 and 0x22 are accepted; t_src_ack=0 while full; 0x33 is held.
   - Releasing c retires 0x11, accepts 0x33, and delivers 0x22 then 0x33 in order.
4. Ack before req: all consumer acks held 1 while the buffer is empty for 5 cycles.
   - No req asserted; tok_cnt unchanged; busy=0.
5. Reset mid-operation: assert reset_n low after k8 and k9 have acked token 0x77.
   - All outputs are 0 immediately.
   - After release, 0x77 is never re-offered and tok_cnt=0.
6. Wrap (CW=4): retire 16 tokens -> tok_cnt returns to 0; the 17th retirement gives tok_cnt=1.
